// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority search: first set req bit starting just after last.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        idx   = '0;
        found = 1'b0;
        cand  = next_idx(32'(last), NREQ);
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                idx   = cand_idx;
                found = 1'b1;
            end
            cand = next_idx(cand, NREQ);
        end
    end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin, burst-locked sharing of one async FIFO write port among NREQ requesters.
module fifo_wr_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned IDX_W     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    input  logic                  wfull,
    output logic [NREQ-1:0]       gnt,
    output logic                  winc,
    output logic [WIDTH-1:0]      wdata,
    output logic [IDX_W-1:0]      gnt_id,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [WIDTH-1:0] slice [NREQ];

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .last  (last),
        .idx   (pick),
        .found (found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            last  <= IDX_W'(NREQ - 1);
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= pick;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Burst end and requester release both hand the port back.
                    if ((winc && cnt == CNT_LAST) || !req[owner]) begin
                        state <= IDLE;
                        last  <= owner;
                    end else if (winc) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slice[i] = data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        busy   = (state == GRANT);
        winc   = busy & req[owner] & ~wfull;
        wdata  = slice[owner];
        gnt_id = owner;
        gnt    = '0;
        if (winc) gnt[owner] = 1'b1;
    end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Bench for fifo_wr_rr_arbiter: vector table plus FIFO-model scoreboard.
module tb_fifo_wr_rr_arbiter;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        wfull;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  gnt_id;
    logic        busy;

    fifo_wr_rr_arbiter #(
        .WIDTH     (8),
        .NREQ      (4),
        .MAX_BURST (4),
        .IDX_W     (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .wfull  (wfull),
        .gnt    (gnt),
        .winc   (winc),
        .wdata  (wdata),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  fifo_q [$];
    logic [7:0]  exp_q  [$];
    bit          rd_en;
    bit          model_on;
    int unsigned src_k [4];
    int unsigned src_n [4];
    logic [7:0]  base  [4];

    logic [3:0]  s_gnt;
    logic        s_winc;
    logic        s_busy;
    logic [7:0]  s_wdata;
    logic [1:0]  s_id;

    typedef struct {
        logic [3:0] req;
        logic       wfull;
        logic       ew;
        logic [3:0] eg;
        logic       eb;
        logic [1:0] ei;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic [3:0] r, input logic wf, input logic ew, input logic [3:0] eg,
                        input logic eb, input logic [1:0] ei);
        vec_t v;
        v.req = r; v.wfull = wf; v.ew = ew; v.eg = eg; v.eb = eb; v.ei = ei;
        vecs.push_back(v);
    endtask

    task automatic apply_model();
        for (int i = 0; i < 4; i++) begin
            req[i]          = (src_k[i] < src_n[i]);
            data[i*8 +: 8]  = base[i] + 8'(src_k[i]);
        end
        wfull = (fifo_q.size() >= DEPTH);
    endtask

    // One clock: sample/check at negedge, then advance FIFO model and requesters.
    task automatic cyc_chk(input bit do_chk, input logic ew, input logic [3:0] eg, input logic eb,
                           input logic [1:0] ei, input string nm);
        logic [7:0] v;
        logic [7:0] e;
        @(negedge clk);
        s_gnt = gnt; s_winc = winc; s_busy = busy; s_wdata = wdata; s_id = gnt_id;
        chk("gnt_onehot", 32'($countones(s_gnt) <= 1), 1);
        chk("gnt_vs_winc", 32'(s_gnt != 4'b0000), 32'(s_winc));
        chk("winc_while_full", 32'(s_winc & wfull), 0);
        if (do_chk) begin
            chk({nm, "_winc"}, s_winc, ew);
            chk({nm, "_gnt"}, s_gnt, eg);
            chk({nm, "_busy"}, s_busy, eb);
            chk({nm, "_gnt_id"}, s_id, ei);
        end
        @(posedge clk);
        #1;
        if (rd_en && fifo_q.size() > 0) begin
            v = fifo_q.pop_front();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got %0h expected nothing", v);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", v, e);
            end
        end
        if (s_winc) fifo_q.push_back(s_wdata);
        if (model_on) begin
            for (int i = 0; i < 4; i++) if (s_gnt[i]) src_k[i]++;
            apply_model();
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        model_on = 1'b0;
        req      = '0;
        wfull    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        model_on = 1'b0;
        req      = '0;
        wfull    = 1'b0;
        rd_en    = 1'b1;
        while (fifo_q.size() > 0 && n < 40) begin
            cyc_chk(0, 0, 0, 0, 0, "");
            n++;
        end
        chk("drain_empty", fifo_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] wp;
        logic [9:0] bp;
        int n;
        rst = 1'b1; req = 4'hF; data = '0; wfull = 1'b0; rd_en = 1'b1; model_on = 1'b0;

        // Reset held with all requests asserted
        for (int c = 0; c < 3; c++) cyc_chk(1, 0, 4'b0000, 0, 0, "reset");

        // Rotation, stall, release and idle vectors
        do_reset();
        data = 32'hA3A2A1A0;
        addv(4'hF, 0, 0, 4'b0000, 0, 0);
        for (int o = 0; o < 4; o++) begin
            for (int b = 0; b < 4; b++) addv(4'hF, 0, 1, 4'(1 << o), 1, 2'(o));
            addv(4'hF, 0, 0, 4'b0000, 0, 2'(o));
        end
        addv(4'hF, 0, 1, 4'b0001, 1, 0);
        addv(4'hF, 1, 0, 4'b0000, 1, 0);
        for (int b = 0; b < 3; b++) addv(4'hF, 0, 1, 4'b0001, 1, 0);
        addv(4'hA, 0, 0, 4'b0000, 0, 0);
        addv(4'hA, 0, 1, 4'b0010, 1, 1);
        addv(4'hA, 0, 1, 4'b0010, 1, 1);
        addv(4'h8, 0, 0, 4'b0000, 1, 1);
        addv(4'h8, 0, 0, 4'b0000, 0, 1);
        addv(4'h8, 0, 1, 4'b1000, 1, 3);
        addv(4'h0, 0, 0, 4'b0000, 1, 3);
        addv(4'h0, 0, 0, 4'b0000, 0, 3);
        for (int i = 0; i < vecs.size(); i++) begin
            req   = vecs[i].req;
            wfull = vecs[i].wfull;
            if (vecs[i].ew) exp_q.push_back(8'hA0 + 8'(vecs[i].ei));
            cyc_chk(1, vecs[i].ew, vecs[i].eg, vecs[i].eb, vecs[i].ei, $sformatf("vec%0d", i));
        end

        // Reset in the middle of owner 2's burst
        do_reset();
        req = 4'b0100;
        cyc_chk(1, 0, 4'b0000, 0, 0, "t6_idle");
        exp_q.push_back(8'hA2);
        cyc_chk(1, 1, 4'b0100, 1, 2, "t6_beat");
        chk("t6_pre_winc", winc, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_winc", winc, 0);
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_gnt_id", gnt_id, 0);
        chk("t6_rst_wdata", wdata, 8'hA0);
        @(posedge clk);
        #1 rst = 1'b0;
        req = 4'b0101;
        cyc_chk(1, 0, 4'b0000, 0, 0, "t6_rel_idle");
        exp_q.push_back(8'hA0);
        cyc_chk(1, 1, 4'b0001, 1, 0, "t6_first");
        req = 4'b0000;
        cyc_chk(0, 0, 0, 0, 0, "");

        // Single requester, six beats
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_k[i] = 0; src_n[i] = 0; base[i] = 8'h00;
        end
        src_n[2] = 6; base[2] = 8'h20;
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h20 + 8'(k));
        model_on = 1'b1;
        apply_model();
        for (int c = 0; c < 10; c++) begin
            cyc_chk(0, 0, 0, 0, 0, "");
            wp[c] = s_winc;
            bp[c] = s_busy;
            if (s_busy) chk("t2_gnt_id", s_id, 2);
        end
        chk("t2_winc_pattern", wp, 10'b0011011110);
        chk("t2_busy_pattern", bp, 10'b0111011110);
        chk("t2_beats", src_k[2], 6);
        drain();

        // Fill to full with no reads, then resume
        do_reset();
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_k[i] = 0; src_n[i] = 8; base[i] = 8'(i * 64);
        end
        for (int h = 0; h < 2; h++)
            for (int o = 0; o < 4; o++)
                for (int b = 0; b < 4; b++) exp_q.push_back(8'(o * 64 + h * 4 + b));
        model_on = 1'b1;
        apply_model();
        n = 0;
        while (fifo_q.size() < DEPTH && n < 40) begin
            cyc_chk(0, 0, 0, 0, 0, "");
            n++;
        end
        chk("t4_fill", fifo_q.size(), DEPTH);
        cyc_chk(1, 0, 4'b0000, 0, 3, "t4_idle");
        for (int c = 0; c < 3; c++) cyc_chk(1, 0, 4'b0000, 1, 0, "t4_stall");
        rd_en = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            cyc_chk(0, 0, 0, 0, 0, "");
            n++;
        end
        chk("t4_all_read", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_src%0d_done", i), src_k[i], 8);

        drain();
        chk("exp_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
